// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Each frame is a start bit, LSB-first data,
// optional parity and one or two stop bits; queued words go out back-to-back.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_BITS-1:0]          data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          uart_txd_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] T_RELOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    state_t               state_q, state_d;
    logic [15:0]          timer_q, timer_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 push, pop, bit_end;
    logic [DATA_BITS-1:0] head;

    assign ready_o      = (count_q != CW'(FIFO_DEPTH));
    assign busy_o       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count_o = count_q;
    assign uart_txd_o   = txd_q;
    assign push         = valid_i && ready_o;
    assign head         = mem_q[rptr_q];
    assign bit_end      = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                txd_d   = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    timer_d = T_RELOAD;
                    bidx_d  = '0;
                    txd_d   = shift_q[0];
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                if (!bit_end) begin
                    timer_d = timer_q - 16'd1;
                end else if (bidx_q == 3'(DATA_BITS - 1)) begin
                    timer_d = T_RELOAD;
                    bidx_d  = '0;
                    if (PARITY != 0) begin
                        state_d = PARITY_BIT;
                        txd_d   = par_q;
                    end else begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end
                end else begin
                    timer_d = T_RELOAD;
                    bidx_d  = bidx_q + 3'd1;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    txd_d   = shift_q[1];
                end
            end
            PARITY_BIT: begin
                if (bit_end) begin
                    state_d = STOP;
                    timer_d = T_RELOAD;
                    bidx_d  = '0;
                    txd_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                if (!bit_end) begin
                    timer_d = timer_q - 16'd1;
                end else if (bidx_q == 3'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    txd_d   = 1'b1;
                end else begin
                    timer_d = T_RELOAD;
                    bidx_d  = bidx_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                txd_d   = 1'b1;
            end
        endcase
        // A waiting word starts from idle, or straight after the final stop cycle.
        if (count_q != '0 && (state_q == IDLE ||
            (state_q == STOP && bit_end && bidx_q == 3'(STOP_BITS - 1)))) begin
            pop     = 1'b1;
            state_d = START;
            timer_d = T_RELOAD;
            bidx_d  = '0;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~(^head) : (^head);
            txd_d   = 1'b0;
        end
    end

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            timer_q <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            timer_q <= timer_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end
endmodule
